da_serial_seq: RTL and testbench

Bit-serial sequencer for the distributed-arithmetic FIR. It time-shares one external 64-entry coefficient LUT across the four input bit-planes instead of instantiating four LUTs. Each accepted 4-bit two's-complement sample is shifted into a 6-tap delay line, and the LUT is addressed once per bit-plane. The partial products are shift-accumulated, saturated and rounded, and the 6-bit result is presented with a valid/ready handshake.

---
 rtl/da_pkg.sv | 9 +
 rtl/da_sat_round.sv | 23 ++
 rtl/da_serial_seq.sv | 87 ++++++++
 tb/tb_da_serial_seq.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/da_pkg.sv
// da_pkg: shared state enum, accumulator widths and saturation bounds for the DA sequencer
package da_pkg;
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
    localparam int ACCW      = 10;
    localparam int SATW      = 9;
    localparam int RND_SHIFT = 3;
    localparam int SAT_MAX   = 255;
    localparam int SAT_MIN   = -256;
endpackage

// File: rtl/da_sat_round.sv
// da_sat_round: clamp acc to 9 bits, round half-up by 2^RND_SHIFT, clamp to YW bits
//   acc : signed accumulator in
//   y   : signed saturated, rounded result out
module da_sat_round
    import da_pkg::*;
#(
    parameter int YW = 6
) (
    input  logic signed [ACCW-1:0] acc,
    output logic signed [YW-1:0]   y
);
    localparam int Y_MAX = 2 ** (YW - 1) - 1;
    localparam int Y_MIN = -(2 ** (YW - 1));
    logic signed [SATW-1:0] s;
    logic signed [ACCW-1:0] sum, r;
    always_comb begin
        s   = (acc > SAT_MAX) ? SATW'(SAT_MAX) : (acc < SAT_MIN) ? SATW'(SAT_MIN) : acc[SATW-1:0];
        // arithmetic shift floors, so adding half an LSB first gives round-half-up
        sum = {s[SATW-1], s} + ACCW'(1 << (RND_SHIFT - 1));
        r   = sum >>> RND_SHIFT;
        y   = (r > Y_MAX) ? YW'(Y_MAX) : (r < Y_MIN) ? YW'(Y_MIN) : r[YW-1:0];
    end
endmodule

// File: rtl/da_serial_seq.sv
// da_serial_seq: bit-serial DA FIR sequencer sharing one external LUT across all bit-planes
//   clk_80/rst_80/clear_80       : clock, sync reset, sync flush
//   in_valid_80/in_ready_80/x_in : sample handshake
//   lut_addr_80/lut_out_80       : external coefficient LUT (combinational)
//   out_valid_80/out_ready_80/y  : result handshake; busy_80 = not idle
module da_serial_seq
    import da_pkg::*;
#(
    parameter int NTAPS = 6,
    parameter int XW    = 4,
    parameter int LW    = 6,
    parameter int YW    = 6
) (
    input  logic                    clk_80,
    input  logic                    rst_80,
    input  logic                    clear_80,
    input  logic                    in_valid_80,
    output logic                    in_ready_80,
    input  logic signed [XW-1:0]    x_in_80,
    output logic [NTAPS-1:0]        lut_addr_80,
    input  logic signed [LW-1:0]    lut_out_80,
    output logic                    out_valid_80,
    input  logic                    out_ready_80,
    output logic signed [YW-1:0]    y_out_80,
    output logic                    busy_80
);
    localparam int BW = $clog2(XW);
    state_t state, state_nxt;
    logic signed [XW-1:0]   taps [NTAPS];
    logic signed [ACCW-1:0] acc, term, acc_nxt;
    logic [BW:0]            cnt;
    logic [BW-1:0]          plane;
    logic                   settle, accept, sign_plane;
    logic signed [YW-1:0]   y_sat;
    // cnt runs through XW planes, then one settle step where the final acc is rounded into y
    assign plane      = cnt[BW-1:0];
    assign settle     = cnt[BW];
    assign accept     = in_ready_80 && in_valid_80 && !clear_80;
    assign sign_plane = state == ACC && !settle && plane == BW'(XW - 1);
    assign term       = ACCW'(lut_out_80) <<< plane;
    assign acc_nxt    = sign_plane ? acc - term : acc + term;
    da_sat_round #(.YW(YW)) u_sat (.acc(acc), .y(y_sat));
    always_comb begin
        state_nxt    = state;
        in_ready_80  = state == IDLE;
        out_valid_80 = state == DONE;
        busy_80      = state != IDLE;
        lut_addr_80  = '0;
        for (int k = 0; k < NTAPS; k++)
            lut_addr_80[k] = state == ACC && !settle && taps[k][plane];
        if (clear_80)
            state_nxt = IDLE;
        else if (accept)
            state_nxt = ACC;
        else if (state == ACC && settle)
            state_nxt = DONE;
        else if (state == DONE && out_ready_80)
            state_nxt = IDLE;
    end
    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            state    <= IDLE;
            acc      <= '0;
            cnt      <= '0;
            y_out_80 <= '0;
            for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
        end else begin
            state <= state_nxt;
            if (clear_80) begin
                acc <= '0;
                cnt <= '0;
                for (int k = 0; k < NTAPS; k++) taps[k] <= '0;
            end else if (accept) begin
                acc     <= '0;
                cnt     <= '0;
                taps[0] <= x_in_80;
                for (int k = 1; k < NTAPS; k++) taps[k] <= taps[k-1];
            end else if (state == ACC) begin
                cnt <= cnt + 1'b1;
                if (settle)
                    y_out_80 <= y_sat;
                else
                    acc <= acc_nxt;
            end
        end
    end
endmodule

// File: tb/tb_da_serial_seq.sv
// tb_da_serial_seq: randomized and directed checks of da_serial_seq against an arithmetic FIR model
module tb_da_serial_seq;
    logic clk_80 = 0, rst_80 = 1, clear_80 = 0, in_valid_80 = 0, out_ready_80 = 1;
    logic signed [3:0] x_in_80 = 0;
    logic [5:0] lut_addr_80;
    logic signed [5:0] lut_out_80, y_hold;
    logic in_ready_80, out_valid_80, busy_80;
    logic signed [5:0] y_out_80;
    int checks = 0, errors = 0;
    int mode = 0;
    int h [6];
    int q [6];

    always #5 clk_80 = ~clk_80;

    da_serial_seq dut (
        .clk_80(clk_80), .rst_80(rst_80), .clear_80(clear_80),
        .in_valid_80(in_valid_80), .in_ready_80(in_ready_80), .x_in_80(x_in_80),
        .lut_addr_80(lut_addr_80), .lut_out_80(lut_out_80),
        .out_valid_80(out_valid_80), .out_ready_80(out_ready_80),
        .y_out_80(y_out_80), .busy_80(busy_80)
    );

    function automatic int lut_val(int a, int m);
        int v = 0;
        if (m == 1) return (a != 0) ? -32 : 0;
        for (int k = 0; k < 6; k++) if ((a >> k) & 1) v += h[k];
        return v;
    endfunction

    assign lut_out_80 = 6'(lut_val(int'(lut_addr_80), mode));

    function automatic int addr_of(int b);
        int a = 0;
        for (int k = 0; k < 6; k++) a |= ((q[k] >> b) & 1) << k;
        return a;
    endfunction

    function automatic int clamp(int v, int lo, int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    // Linear LUTs reduce to a plain dot product; the nonlinear saturation LUT is summed per bit-plane
    function automatic int ref_y();
        int acc = 0;
        if (mode == 1) begin
            for (int b = 0; b < 4; b++)
                acc += (b == 3 ? -8 : (1 << b)) * lut_val(addr_of(b), 1);
        end else begin
            for (int k = 0; k < 6; k++) acc += h[k] * q[k];
        end
        return clamp((clamp(acc, -256, 255) + 4) >>> 3, -32, 31);
    endfunction

    task automatic check(string tag, logic signed [31:0] obs, logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_80);
        #1;
    endtask

    task automatic do_reset();
        rst_80 = 1;
        tick();
        tick();
        rst_80 = 0;
        for (int k = 0; k < 6; k++) q[k] = 0;
    endtask

    task automatic run_sample(input int x, input string tag);
        int n = 0;
        while (!in_ready_80 && n < 20) begin tick(); n++; end
        check({tag, "_ready"}, in_ready_80, 1);
        x_in_80 = 4'(x);
        in_valid_80 = 1;
        tick();
        in_valid_80 = 0;
        for (int k = 5; k > 0; k--) q[k] = q[k-1];
        q[0] = int'($signed(4'(x)));
        check({tag, "_addr0"}, {26'b0, lut_addr_80}, addr_of(0));
        n = 0;
        while (!out_valid_80 && n < 20) begin tick(); n++; end
        check({tag, "_latency"}, n, 5);
        check({tag, "_y"}, $signed(y_out_80), ref_y());
        if (out_ready_80) begin
            tick();
            check({tag, "_idle"}, {busy_80, out_valid_80, in_ready_80}, 3'b001);
        end
    endtask

    initial begin
        h = '{5, 0, 0, 0, 0, 0};
        do_reset();
        check("rst_ready", in_ready_80, 1);
        check("rst_valid", out_valid_80, 0);
        check("rst_y", $signed(y_out_80), 0);
        check("rst_busy", busy_80, 0);
        check("rst_addr", {26'b0, lut_addr_80}, 0);

        run_sample(3, "x3");
        check("x3_const", $signed(y_out_80), 2);
        do_reset();
        run_sample(-8, "xm8");
        check("xm8_const", $signed(y_out_80), -5);

        do_reset();
        mode = 1;
        for (int i = 0; i < 6; i++) run_sample(-8, "sat");
        check("sat_const", $signed(y_out_80), 31);

        do_reset();
        mode = 2;
        for (int k = 0; k < 6; k++) h[k] = $urandom_range(10) - 5;
        for (int i = 0; i < 20; i++) begin
            out_ready_80 = 1'($urandom_range(1));
            run_sample($urandom_range(15), "rnd");
            if (!out_ready_80) begin
                repeat ($urandom_range(3)) begin
                    tick();
                    check("rnd_hold", out_valid_80, 1);
                end
                out_ready_80 = 1;
                tick();
                check("rnd_release", in_ready_80, 1);
            end
        end

        out_ready_80 = 0;
        run_sample(6, "bp");
        y_hold = y_out_80;
        for (int i = 0; i < 10; i++) begin
            in_valid_80 = (i == 3);
            x_in_80 = 4'sd7;
            tick();
            check("bp_y_stable", $signed(y_out_80), $signed(y_hold));
            check("bp_in_ready", in_ready_80, 0);
        end
        in_valid_80 = 0;
        out_ready_80 = 1;
        tick();
        check("bp_release", {busy_80, in_ready_80}, 2'b01);
        run_sample(-3, "bp_next");

        mode = 0;
        h = '{5, 0, 0, 0, 0, 0};
        x_in_80 = 4'sd5;
        in_valid_80 = 1;
        tick();
        in_valid_80 = 0;
        tick();
        clear_80 = 1;
        in_valid_80 = 1;
        x_in_80 = 4'sd7;
        tick();
        clear_80 = 0;
        in_valid_80 = 0;
        for (int k = 0; k < 6; k++) q[k] = 0;
        check("clr_busy", busy_80, 0);
        check("clr_valid", out_valid_80, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 8; i++) begin tick(); seen |= out_valid_80; end
            check("clr_no_valid", seen, 0);
        end
        mode = 2;
        h = '{1, 2, 3, 4, 5, 6};
        run_sample(3, "clr_next");
        check("clr_next_const", $signed(y_out_80), 0);
        mode = 0;
        h = '{5, 0, 0, 0, 0, 0};
        run_sample(3, "clr_x3");
        check("clr_x3_const", $signed(y_out_80), 2);

        out_ready_80 = 0;
        run_sample(3, "rstd");
        rst_80 = 1;
        tick();
        rst_80 = 0;
        check("rstd_valid", out_valid_80, 0);
        check("rstd_y", $signed(y_out_80), 0);
        check("rstd_ready", in_ready_80, 1);
        out_ready_80 = 1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
